// File: rtl/ym3438_pkg.sv
// Shared types, ladder offsets and output saturation for the YM3438 mixer.
// The ladder constants are used only when YM3438_MIXER_LADDER_EN is defined.
package ym3438_pkg;

    typedef logic [3:0] ch_idx_t;

    localparam int LADDER_POS  = 4;
    localparam int LADDER_NEG  = 3;
    localparam int LADDER_MUTE = 4;

    // Clamp a 32-bit signed value into the signed range of a w-bit word.
    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] x,
                                                         input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/ym3438_mixer_side.sv
// One stereo side of the mixer: pan gating, frame accumulator and saturated output.
// Optional YM3438_MIXER_LADDER_EN replaces the pan mask with the DAC crossover offsets.
module ym3438_mixer_side
    import ym3438_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int OUT_W = 14,
    parameter int ACC_W = IN_W + 4
) (
    input  logic                    MCLK,
    input  logic                    reset,
    input  logic                    step,
    input  logic                    pan,
    input  logic                    base_zero,
    input  logic                    add,
    input  logic                    last,
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] out
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W-1:0] contrib;
    logic signed [ACC_W-1:0] sum_p0;

    assign v = ACC_W'(value);

`ifdef YM3438_MIXER_LADDER_EN
    // Even a muted channel contributes the ladder's crossover step.
    always_comb begin
        contrib = '0;
        if (v[ACC_W-1])
            contrib = pan ? v - ACC_W'(LADDER_NEG) : -ACC_W'(LADDER_MUTE);
        else
            contrib = pan ? v + ACC_W'(LADDER_POS) : ACC_W'(LADDER_MUTE);
    end
`else
    assign contrib = pan ? v : '0;
`endif

    // base_zero drops the partial frame; add=0 with it discards the sample too.
    assign sum_p0 = (base_zero ? '0 : acc) + (add ? contrib : '0);

    // ---- frame accumulation / output latch ----
    always_ff @(posedge MCLK) begin
        if (reset) begin
            acc <= '0;
            out <= '0;
        end else if (step) begin
            if (last) begin
                out <= OUT_W'(sat_to_width(32'(sum_p0), OUT_W));
                acc <= '0;
            end else begin
                acc <= sum_p0;
            end
        end
    end

endmodule

// File: rtl/ym3438_mixer_acc.sv
// Stereo output accumulator: per-channel pan, frame sequencing, saturation, valid strobe.
// Build option: YM3438_MIXER_LADDER_EN selects the DAC ladder crossover contribution.
module ym3438_mixer_acc
    import ym3438_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int IN_W   = 9,
    parameter int OUT_W  = 14,
    parameter int ACC_W  = IN_W + 4
) (
    input  logic                    MCLK,
    input  logic                    reset,
    input  logic                    c1,
    input  logic                    c2,
    input  logic                    ch_valid,
    input  logic [3:0]              ch_idx,
    input  logic signed [IN_W-1:0]  ch_value,
    input  logic                    pan_l,
    input  logic                    pan_r,
    output logic signed [OUT_W-1:0] out_l,
    output logic signed [OUT_W-1:0] out_r,
    output logic                    out_valid,
    output logic                    seq_err,
    input  logic                    seq_err_clr
);

    localparam ch_idx_t LAST_IDX = ch_idx_t'(NUM_CH - 1);

    ch_idx_t exp_idx;
    logic    accept;
    logic    idx_ok;
    logic    restart;
    logic    frame_end;
    logic    valid_pend;

    // exp_idx never exceeds LAST_IDX, so out-of-range indices always mismatch.
    assign accept    = c1 & ch_valid;
    assign idx_ok    = (ch_idx == exp_idx);
    assign restart   = ~idx_ok & (ch_idx == '0);
    assign frame_end = accept & idx_ok & (exp_idx == LAST_IDX);

    ym3438_mixer_side #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) u_side_l (
        .MCLK      (MCLK),
        .reset     (reset),
        .step      (accept),
        .pan       (pan_l),
        .base_zero (~idx_ok),
        .add       (idx_ok | restart),
        .last      (frame_end),
        .value     (ch_value),
        .out       (out_l)
    );

    ym3438_mixer_side #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) u_side_r (
        .MCLK      (MCLK),
        .reset     (reset),
        .step      (accept),
        .pan       (pan_r),
        .base_zero (~idx_ok),
        .add       (idx_ok | restart),
        .last      (frame_end),
        .value     (ch_value),
        .out       (out_r)
    );

    // ---- sequencing ----
    always_ff @(posedge MCLK) begin
        if (reset) begin
            exp_idx <= '0;
            seq_err <= 1'b0;
        end else if (c1) begin
            if (accept) begin
                if (!idx_ok)
                    exp_idx <= restart ? ch_idx_t'(1) : '0;
                else if (exp_idx == LAST_IDX)
                    exp_idx <= '0;
                else
                    exp_idx <= exp_idx + ch_idx_t'(1);
            end
            // A fresh error outranks a simultaneous clear.
            if (accept && !idx_ok)
                seq_err <= 1'b1;
            else if (seq_err_clr)
                seq_err <= 1'b0;
        end
    end

    // ---- out_valid: latched on c1, shown on the next c2, dropped at the next c1 ----
    always_ff @(posedge MCLK) begin
        if (reset) begin
            valid_pend <= 1'b0;
            out_valid  <= 1'b0;
        end else if (c1) begin
            valid_pend <= frame_end;
            out_valid  <= 1'b0;
        end else if (c2 && valid_pend) begin
            valid_pend <= 1'b0;
            out_valid  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ym3438_mixer_acc.sv
// Directed bench for ym3438_mixer_acc; a second instance with OUT_W=9 covers saturation.
// Ladder expectations are selected when YM3438_MIXER_LADDER_EN is defined.
module tb_ym3438_mixer_acc;

    logic              MCLK = 1'b0;
    logic              reset;
    logic              c1;
    logic              c2;
    logic              ch_valid;
    logic [3:0]        ch_idx;
    logic signed [8:0] ch_value;
    logic              pan_l;
    logic              pan_r;
    logic              seq_err_clr;

    logic signed [13:0] out_l;
    logic signed [13:0] out_r;
    logic               out_valid;
    logic               seq_err;
    logic signed [8:0]  out_l9;
    logic signed [8:0]  out_r9;
    logic               out_valid9;
    logic               seq_err9;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;

    ym3438_mixer_acc dut (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .ch_valid(ch_valid),
        .ch_idx(ch_idx), .ch_value(ch_value), .pan_l(pan_l), .pan_r(pan_r),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .seq_err(seq_err),
        .seq_err_clr(seq_err_clr)
    );

    ym3438_mixer_acc #(.OUT_W(9)) dut9 (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .ch_valid(ch_valid),
        .ch_idx(ch_idx), .ch_value(ch_value), .pan_l(pan_l), .pan_r(pan_r),
        .out_l(out_l9), .out_r(out_r9), .out_valid(out_valid9), .seq_err(seq_err9),
        .seq_err_clr(seq_err_clr)
    );

    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) begin
        #1;
        if (out_valid) pulses++;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One c1 slot followed by one c2 phase.
    task automatic slot(input logic v, input logic [3:0] idx, input int val,
                        input logic pl, input logic pr);
        @(negedge MCLK);
        c1 = 1'b1; c2 = 1'b0; ch_valid = v; ch_idx = idx;
        ch_value = 9'(val); pan_l = pl; pan_r = pr;
        @(negedge MCLK);
        c1 = 1'b0; c2 = 1'b1; ch_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) slot(1'b0, 4'd0, 0, 1'b0, 1'b0);
    endtask

    task automatic frame_const(input int val, input logic pl, input logic pr);
        for (int i = 0; i < 6; i++) slot(1'b1, 4'(i), val, pl, pr);
    endtask

    initial begin
        reset = 1'b1; c1 = 1'b0; c2 = 1'b0; ch_valid = 1'b0; ch_idx = 4'd0;
        ch_value = '0; pan_l = 1'b0; pan_r = 1'b0; seq_err_clr = 1'b0;
        repeat (3) @(negedge MCLK);
        reset = 1'b0;
        #1;
        check("rst_out_l", out_l, 0);
        check("rst_out_r", out_r, 0);
        check("rst_valid", out_valid, 0);
        check("rst_seq_err", seq_err, 0);

`ifdef YM3438_MIXER_LADDER_EN
        frame_const(0, 1'b1, 1'b1);
        idle(1);
        check("ladder_zero_l", out_l, 24);
        check("ladder_zero_r", out_r, 24);
        check("ladder_zero_l9", out_l9, 24);
        frame_const(-1, 1'b0, 1'b0);
        idle(1);
        check("ladder_mute_l", out_l, -24);
        check("ladder_mute_r", out_r, -24);
        check("ladder_mute_r9", out_r9, -24);
        check("ladder_pulses", pulses, 2);
`else
        // Values 1..6, all pans on.
        p0 = pulses;
        for (int i = 0; i < 6; i++) slot(1'b1, 4'(i), i + 1, 1'b1, 1'b1);
        check("valid_before_c2", out_valid, 0);
        @(posedge MCLK); #1;
        check("valid_at_c2", out_valid, 1);
        check("valid9_at_c2", out_valid9, 1);
        idle(1);
        check("valid_dropped", out_valid, 0);
        check("sum_l", out_l, 21);
        check("sum_r", out_r, 21);
        check("sum_l9", out_l9, 21);
        check("one_pulse", pulses - p0, 1);
        check("no_seq_err", seq_err, 0);

        idle(3);
        check("hold_l", out_l, 21);
        check("hold_pulses", pulses - p0, 1);

        // Pan split.
        slot(1'b1, 4'd0, 100, 1'b1, 1'b0);
        slot(1'b1, 4'd1, -50, 1'b0, 1'b1);
        for (int i = 2; i < 6; i++) slot(1'b1, 4'(i), 0, 1'b1, 1'b1);
        idle(1);
        check("pan_l", out_l, 100);
        check("pan_r", out_r, -50);

        // Saturation at OUT_W=9, none at OUT_W=14.
        frame_const(255, 1'b1, 1'b1);
        idle(1);
        check("sat_pos_l9", out_l9, 255);
        check("sat_pos_r9", out_r9, 255);
        check("nosat_pos_l", out_l, 1530);
        frame_const(-256, 1'b1, 1'b1);
        idle(1);
        check("sat_neg_l9", out_l9, -256);
        check("nosat_neg_l", out_l, -1536);

        // Skipped index: frame discarded, no strobe.
        p0 = pulses;
        slot(1'b1, 4'd0, 7, 1'b1, 1'b1);
        slot(1'b1, 4'd1, 7, 1'b1, 1'b1);
        slot(1'b1, 4'd3, 7, 1'b1, 1'b1);
        idle(2);
        check("skip_seq_err", seq_err, 1);
        check("skip_no_pulse", pulses - p0, 0);
        check("skip_hold_l", out_l, -1536);
        frame_const(2, 1'b1, 1'b1);
        idle(1);
        check("after_err_l", out_l, 12);
        check("sticky_err", seq_err, 1);
        seq_err_clr = 1'b1;
        idle(1);
        seq_err_clr = 1'b0;
        check("err_cleared", seq_err, 0);

        // Out-of-range index, with clear in the same slot: error wins.
        seq_err_clr = 1'b1;
        slot(1'b1, 4'd6, 1, 1'b1, 1'b1);
        seq_err_clr = 1'b0;
        check("range_err_wins", seq_err, 1);
        seq_err_clr = 1'b1;
        idle(1);
        seq_err_clr = 1'b0;

        // Out-of-order index 0 restarts the frame with that sample.
        for (int i = 0; i < 3; i++) slot(1'b1, 4'(i), 1, 1'b1, 1'b1);
        slot(1'b1, 4'd0, 5, 1'b1, 1'b1);
        for (int i = 1; i < 6; i++) slot(1'b1, 4'(i), 1, 1'b1, 1'b1);
        idle(1);
        check("restart_l", out_l, 10);
        check("restart_err", seq_err, 1);

        // Reset mid-frame.
        for (int i = 0; i < 3; i++) slot(1'b1, 4'(i), 1, 1'b1, 1'b1);
        @(negedge MCLK); reset = 1'b1;
        @(negedge MCLK); reset = 1'b0;
        #1;
        check("midrst_l", out_l, 0);
        check("midrst_r", out_r, 0);
        check("midrst_err", seq_err9, 0);

        // Full frame with idle slots inside: idle slots must not advance the index.
        for (int i = 0; i < 3; i++) slot(1'b1, 4'(i), 1, 1'b1, 1'b1);
        idle(2);
        for (int i = 3; i < 6; i++) slot(1'b1, 4'(i), 1, 1'b1, 1'b1);
        idle(1);
        check("post_rst_l", out_l, 6);
        check("post_rst_r", out_r, 6);
        check("post_rst_err", seq_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
